dffe_checker: RTL and testbench

DFFE_CHECKER -- requirements
Module: dffe_checker

---
 rtl/dffe_checker_pkg.sv | 15 +
 rtl/dffe_ref_model.sv | 45 ++++
 rtl/dffe_checker.sv | 116 +++++++++++
 tb/tb_dffe_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dffe_checker_pkg.sv
// Shared state encoding and default sizing for the DFFE output checker.
package dffe_checker_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2,
      StHalt = 2'd3
   } state_e;

   localparam int unsigned DefCntW   = 16;
   localparam int unsigned DefErrW   = 8;
   localparam int unsigned DefMaxErr = 16;

endpackage

// File: rtl/dffe_ref_model.sv
// Reference DFFE with async preset/clear priority; tracks whether a known value was ever loaded.
module dffe_ref_model (
   input  logic clk,
   input  logic clear,
   input  logic restart,
   input  logic update,
   input  logic d_obs,
   input  logic e_obs,
   input  logic pre_n_obs,
   input  logic clr_n_obs,
   output logic exp,
   output logic exp_valid,
   output logic both_low
);

   logic exp_q, exp_valid_q, both_low_q;

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         exp_q       <= 1'b0;
         exp_valid_q <= 1'b0;
         both_low_q  <= 1'b0;
      end else if (restart) begin
         exp_valid_q <= 1'b0;
      end else if (update) begin
         // Remembered so the next compare can skip q_bar when both controls fought.
         both_low_q <= ~pre_n_obs & ~clr_n_obs;
         if (!pre_n_obs) begin
            exp_q       <= 1'b1;
            exp_valid_q <= 1'b1;
         end else if (!clr_n_obs) begin
            exp_q       <= 1'b0;
            exp_valid_q <= 1'b1;
         end else if (e_obs) begin
            exp_q       <= d_obs;
            exp_valid_q <= 1'b1;
         end
      end
   end

   assign exp       = exp_q;
   assign exp_valid = exp_valid_q;
   assign both_low  = both_low_q;

endmodule

// File: rtl/dffe_checker.sv
// Run-controlled checker comparing an observed DFFE against a one-cycle-delayed reference model.
module dffe_checker
   import dffe_checker_pkg::*;
#(
   parameter int unsigned CNT_W   = DefCntW,
   parameter int unsigned ERR_W   = DefErrW,
   parameter int unsigned MAX_ERR = DefMaxErr
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic             stop,
   input  logic             d_obs,
   input  logic             e_obs,
   input  logic             pre_n_obs,
   input  logic             clr_n_obs,
   input  logic             q_obs,
   input  logic             q_bar_obs,
   output logic             busy,
   output logic             done,
   output logic             halted,
   output logic             mismatch,
   output logic [CNT_W-1:0] sample_count,
   output logic [ERR_W-1:0] err_count
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   sample_count_q, sample_count_d;
   logic [ERR_W-1:0]   err_count_q, err_count_d;
   logic               mismatch_q, mismatch_d;
   logic               enter_run, leave_run, halt_hit, update, compare, err;
   logic               exp, exp_valid, both_low;

   assign halt_hit = (MAX_ERR != 0) && (32'(err_count_q) >= MAX_ERR);

   always_comb begin
      state_d   = state_q;
      enter_run = 1'b0;
      leave_run = 1'b0;
      unique case (state_q)
         StIdle, StDone, StHalt: begin
            if (start) begin
               state_d   = StRun;
               enter_run = 1'b1;
            end
         end
         StRun: begin
            // Stop wins over a coincident start, which is ignored in RUN anyway.
            if (stop) begin
               state_d   = StDone;
               leave_run = 1'b1;
            end else if (halt_hit) begin
               state_d   = StHalt;
               leave_run = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign update  = (state_q == StRun) && !leave_run;
   assign compare = update && exp_valid;
   assign err     = both_low ? ~q_obs : ((q_obs != exp) || (q_bar_obs == q_obs));

   always_comb begin
      sample_count_d = sample_count_q;
      err_count_d    = err_count_q;
      mismatch_d     = 1'b0;
      if (enter_run) begin
         sample_count_d = '0;
         err_count_d    = '0;
      end else if (compare) begin
         if (sample_count_q != '1) sample_count_d = sample_count_q + CNT_W'(1);
         if (err) begin
            mismatch_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q        <= StIdle;
         sample_count_q <= '0;
         err_count_q    <= '0;
         mismatch_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         sample_count_q <= sample_count_d;
         err_count_q    <= err_count_d;
         mismatch_q     <= mismatch_d;
      end
   end

   dffe_ref_model u_ref (
      .clk       (clk),
      .clear     (clear),
      .restart   (enter_run),
      .update    (update),
      .d_obs     (d_obs),
      .e_obs     (e_obs),
      .pre_n_obs (pre_n_obs),
      .clr_n_obs (clr_n_obs),
      .exp       (exp),
      .exp_valid (exp_valid),
      .both_low  (both_low)
   );

   assign busy         = (state_q == StRun);
   assign done         = (state_q == StDone) || (state_q == StHalt);
   assign halted       = (state_q == StHalt);
   assign mismatch     = mismatch_q;
   assign sample_count = sample_count_q;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_dffe_checker.sv
// Scoreboard bench: a default checker and a MAX_ERR=3 checker watch the same flop stimulus.
module tb_dffe_checker;

   localparam int CntMax = 65535;
   localparam int ErrMax = 255;

   logic clk = 1'b0;
   logic clear, start, stop, d_obs, e_obs, pre_n_obs, clr_n_obs, q_obs, q_bar_obs;
   logic busy0, done0, halted0, mismatch0, busy1, done1, halted1, mismatch1;
   logic [15:0] sc0, sc1;
   logic [7:0]  ec0, ec1;

   int n_checks = 0;
   int n_fail   = 0;
   int mm_seen  = 0;
   bit ff       = 1'b0;

   typedef struct {
      int st;  // 0 idle, 1 run, 2 done, 3 halt
      bit ex;
      bit vld;
      bit both;
      int samp;
      int err;
      bit mm;
   } mdl_t;

   typedef struct {
      mdl_t a;
      mdl_t b;
   } exp_t;

   exp_t sb[$];
   mdl_t ma, mb;

   always #5 clk = ~clk;

   dffe_checker u_dut0 (
      .clk(clk), .clear(clear), .start(start), .stop(stop), .d_obs(d_obs), .e_obs(e_obs),
      .pre_n_obs(pre_n_obs), .clr_n_obs(clr_n_obs), .q_obs(q_obs), .q_bar_obs(q_bar_obs),
      .busy(busy0), .done(done0), .halted(halted0), .mismatch(mismatch0),
      .sample_count(sc0), .err_count(ec0)
   );

   dffe_checker #(.CNT_W(16), .ERR_W(8), .MAX_ERR(3)) u_dut1 (
      .clk(clk), .clear(clear), .start(start), .stop(stop), .d_obs(d_obs), .e_obs(e_obs),
      .pre_n_obs(pre_n_obs), .clr_n_obs(clr_n_obs), .q_obs(q_obs), .q_bar_obs(q_bar_obs),
      .busy(busy1), .done(done1), .halted(halted1), .mismatch(mismatch1),
      .sample_count(sc1), .err_count(ec1)
   );

   function automatic mdl_t mreset();
      mdl_t m;
      m.st = 0; m.ex = 0; m.vld = 0; m.both = 0; m.samp = 0; m.err = 0; m.mm = 0;
      return m;
   endfunction

   function automatic mdl_t mstep(mdl_t m, int max_err, bit s, bit sp, bit dd, bit ee,
                                  bit pn, bit cn, bit q, bit qb);
      mdl_t n;
      bit   bad;
      n = m;
      n.mm = 0;
      if (m.st == 1) begin
         if (sp) n.st = 2;
         else if (max_err != 0 && m.err >= max_err) n.st = 3;
         else begin
            if (m.vld) begin
               n.samp = (m.samp == CntMax) ? m.samp : m.samp + 1;
               bad = m.both ? !q : ((q != m.ex) || (qb == q));
               if (bad) begin
                  n.mm  = 1;
                  n.err = (m.err == ErrMax) ? m.err : m.err + 1;
               end
            end
            n.both = !pn && !cn;
            if (!pn) begin n.ex = 1; n.vld = 1; end
            else if (!cn) begin n.ex = 0; n.vld = 1; end
            else if (ee) begin n.ex = dd; n.vld = 1; end
         end
      end else if (s) begin
         n.st = 1; n.samp = 0; n.err = 0; n.vld = 0;
      end
      return n;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      check_eq({tag, ".busy0"},   busy0,     e.a.st == 1);
      check_eq({tag, ".done0"},   done0,     e.a.st >= 2);
      check_eq({tag, ".halted0"}, halted0,   e.a.st == 3);
      check_eq({tag, ".mm0"},     mismatch0, e.a.mm);
      check_eq({tag, ".samp0"},   sc0,       e.a.samp);
      check_eq({tag, ".err0"},    ec0,       e.a.err);
      check_eq({tag, ".busy1"},   busy1,     e.b.st == 1);
      check_eq({tag, ".done1"},   done1,     e.b.st >= 2);
      check_eq({tag, ".halted1"}, halted1,   e.b.st == 3);
      check_eq({tag, ".mm1"},     mismatch1, e.b.mm);
      check_eq({tag, ".samp1"},   sc1,       e.b.samp);
      check_eq({tag, ".err1"},    ec1,       e.b.err);
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, ".busy0"}, busy0, 0);
      check_eq({tag, ".done0"}, done0, 0);
      check_eq({tag, ".halt0"}, halted0, 0);
      check_eq({tag, ".mm0"},   mismatch0, 0);
      check_eq({tag, ".samp0"}, sc0, 0);
      check_eq({tag, ".err0"},  ec0, 0);
      check_eq({tag, ".busy1"}, busy1, 0);
      check_eq({tag, ".err1"},  ec1, 0);
   endtask

   // One clock: drive inputs, predict, advance the flop under test, then score.
   task automatic cycle(input string tag, input bit s, input bit sp, input bit dd, input bit ee,
                        input bit pn, input bit cn, input bit qf, input bit qfv, input bit qbf);
      exp_t e;
      start = s; stop = sp; d_obs = dd; e_obs = ee; pre_n_obs = pn; clr_n_obs = cn;
      q_obs     = qf ? qfv : ff;
      q_bar_obs = qbf ? q_obs : ~q_obs;
      ma  = mstep(ma, 16, s, sp, dd, ee, pn, cn, q_obs, q_bar_obs);
      mb  = mstep(mb, 3, s, sp, dd, ee, pn, cn, q_obs, q_bar_obs);
      e.a = ma;
      e.b = mb;
      sb.push_back(e);
      @(posedge clk);
      if (!pre_n_obs) ff = 1'b1;
      else if (!clr_n_obs) ff = 1'b0;
      else if (e_obs) ff = d_obs;
      #1;
      if (mismatch0) mm_seen++;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s.scoreboard: got empty queue required one entry", tag);
      end else begin
         check_outputs(tag, sb.pop_front());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear = 0; start = 0; stop = 0; d_obs = 0; e_obs = 0; pre_n_obs = 1; clr_n_obs = 1;
      q_obs = 0; q_bar_obs = 1;
      ma = mreset();
      mb = mreset();
      #2 check_reset("por");
      @(posedge clk);
      #1 clear = 1;
      cycle("idle", 0, 0, 0, 0, 1, 1, 0, 0, 0);

      // Clean run
      cycle("clean.start", 1, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) cycle("clean", 0, 0, i[0], 1, 1, 1, 0, 0, 0);
      mm_seen = 0;
      cycle("clean.stop", 0, 1, 0, 0, 1, 1, 0, 0, 0);
      check_eq("clean.samples", sc0, 19);
      check_eq("clean.errs", ec0, 0);
      check_eq("clean.done", done0, 1);

      // Stuck-at 0
      cycle("stuck.start", 1, 0, 0, 0, 1, 1, 0, 0, 0);
      mm_seen = 0;
      for (int i = 0; i < 5; i++) cycle("stuck", 0, 0, 1, 1, 1, 1, 1, 0, 0);
      check_eq("stuck.pulses", mm_seen, 4);
      cycle("stuck.stop", 0, 1, 0, 0, 1, 1, 0, 0, 0);
      check_eq("stuck.errs", ec0, 4);

      // Complement error on one cycle
      cycle("comp.start", 1, 0, 0, 0, 1, 1, 0, 0, 0);
      mm_seen = 0;
      for (int i = 0; i < 6; i++) cycle("comp", 0, 0, i[0], 1, 1, 1, 0, 0, i == 3);
      cycle("comp.stop", 0, 1, 0, 0, 1, 1, 0, 0, 0);
      check_eq("comp.pulses", mm_seen, 1);
      check_eq("comp.errs", ec0, 1);

      // Priority, enable hold, start ignored in RUN, start+stop acts as stop
      cycle("prio.start", 1, 0, 0, 0, 1, 1, 0, 0, 0);
      cycle("prio.load0", 0, 0, 0, 1, 1, 1, 0, 0, 0);
      cycle("prio.both", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("prio.qbar", 0, 0, 0, 0, 1, 1, 0, 0, 1);
      for (int i = 0; i < 10; i++) cycle("hold", 0, 0, i[0], 0, 1, 1, 0, 0, 0);
      cycle("prio.restart", 1, 0, 0, 0, 1, 1, 0, 0, 0);
      check_eq("prio.still_busy", busy0, 1);
      cycle("prio.clr", 0, 0, 1, 1, 1, 0, 0, 0, 0);
      cycle("prio.clrchk", 0, 0, 0, 0, 1, 1, 0, 0, 0);
      cycle("prio.both2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("prio.q0", 0, 0, 0, 0, 1, 1, 1, 0, 0);
      cycle("prio.ss", 1, 1, 0, 0, 1, 1, 0, 0, 0);
      check_eq("prio.samples", sc0, 17);
      check_eq("prio.errs", ec0, 1);
      check_eq("prio.done", done0, 1);

      // Halt at MAX_ERR=3
      cycle("halt.start", 1, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) cycle("halt", 0, 0, 1, 1, 1, 1, 1, 0, 0);
      check_eq("halt.halted", halted1, 1);
      check_eq("halt.busy", busy1, 0);
      check_eq("halt.errs", ec1, 3);
      check_eq("halt.samples", sc1, 3);
      cycle("halt.stop", 0, 1, 0, 0, 1, 1, 0, 0, 0);

      // Reset in the middle of a run
      cycle("mrst.start", 1, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle("mrst", 0, 0, 1, 1, 1, 1, 1, 0, 0);
      start = 0; stop = 0; e_obs = 0; pre_n_obs = 1; clr_n_obs = 1;
      #3 clear = 0;
      #1 check_reset("mrst.async");
      ma = mreset();
      mb = mreset();
      repeat (2) @(posedge clk);
      #1 clear = 1;
      cycle("mrst.idle", 0, 0, 0, 0, 1, 1, 0, 0, 0);
      cycle("mrst.run", 1, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle("mrst.clean", 0, 0, i[0], 1, 1, 1, 0, 0, 0);
      cycle("mrst.stop", 0, 1, 0, 0, 1, 1, 0, 0, 0);
      check_eq("mrst.samples", sc0, 4);
      check_eq("mrst.errs", ec0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
